// File: rtl/gf11_perm_pkg.sv
// Shared constants for the GF(11) pseudo-random interleaver / deinterleaver pair.
// Holds the recurrence coefficients, the seed, the state type and the reference tables.
package gf11_perm_pkg;

  localparam int N = 8;
  localparam int P = 11;

  localparam logic [3:0] C1 = 4'd1;
  localparam logic [3:0] C2 = 4'd1;
  localparam logic [3:0] C3 = 4'd1;
  localparam logic [3:0] C4 = 4'd3;

  localparam logic [3:0] SEED0 = 4'd0;
  localparam logic [3:0] SEED1 = 4'd7;
  localparam logic [3:0] SEED2 = 4'd10;

  typedef enum logic {
    GEN = 1'b0,
    RUN = 1'b1
  } state_t;

  // Element j sits at index j: Q = {0,6,2,4,5,7,3,1}, Pf = {0,7,2,6,3,4,1,5}
  localparam logic [7:0][2:0] Q_ROM  = {3'd1, 3'd3, 3'd7, 3'd5, 3'd4, 3'd2, 3'd6, 3'd0};
  localparam logic [7:0][2:0] PF_ROM = {3'd5, 3'd1, 3'd4, 3'd3, 3'd6, 3'd2, 3'd7, 3'd0};

endpackage

// File: rtl/gf11_seq_gen.sv
// Three-register mod-11 recurrence shared by the interleaver and deinterleaver.
// d2' = ((C1*d0 + C2*d1 + C3*d2) mod P * C4) mod P, then the registers shift down.
module gf11_seq_gen
  import gf11_perm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       reseed,
  output logic [3:0] d0
);

  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d2_nxt;
  logic [7:0] lin;

  function automatic logic [3:0] mod_p(input logic [7:0] x);
    logic [7:0] r;
    r = x % 8'(P);
    return r[3:0];
  endfunction

  // Sum is reduced before the multiply so every operand stays within 0..10
  always_comb begin
    lin    = {4'd0, C1} * {4'd0, d0} + {4'd0, C2} * {4'd0, d1} + {4'd0, C3} * {4'd0, d2};
    d2_nxt = mod_p({4'd0, mod_p(lin)} * {4'd0, C4});
  end

  always_ff @(posedge clk) begin
    if (rst || reseed) begin
      d0 <= SEED0;
      d1 <= SEED1;
      d2 <= SEED2;
    end else if (step) begin
      d0 <= d1;
      d1 <= d2;
      d2 <= d2_nxt;
    end
  end

endmodule

// File: rtl/deinterleaver_gf11.sv
// Receive-side GF(11) deinterleaver: builds the inverse permutation Q after reset/regen,
// then streams out[j] = in[Q[j]]. Macro DEINT_ROM_TABLE_EN replaces the generator by a fixed table.
module deinterleaver_gf11 #(
  parameter int N = 8,
  parameter int P = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         regen,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] Secventa_Intretesuta,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Secventa_Deintretesuta,
  output logic         table_ready
);
  import gf11_perm_pkg::*;

  if (N != 8 || P != 11) begin : g_bad_cfg
    $error("deinterleaver_gf11 supports only N=8, P=11");
  end

  state_t          state_q;
  state_t          state_d;
  logic [7:0][2:0] q_tab;
  logic            xfer;
  logic            vld_p1;
  logic [N-1:0]    data_p1;

  function automatic logic [N-1:0] apply_q(input logic [N-1:0] x, input logic [7:0][2:0] q);
    logic [N-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) r[j] = x[q[j]];
    return r;
  endfunction

`ifdef DEINT_ROM_TABLE_EN
  assign q_tab = Q_ROM;

  always_comb begin
    state_d = RUN;
  end
`else
  logic [3:0] gen_d0;
  logic       gen_unused;
  logic [2:0] k;
  logic [2:0] cnt;
  logic [7:0] used;
  logic       accept;

  gf11_seq_gen u_gen (
    .clk    (clk),
    .rst    (rst),
    .step   (state_q == GEN),
    .reseed (regen),
    .d0     (gen_d0)
  );

  assign k          = gen_d0[2:0];
  assign gen_unused = gen_d0[3];
  assign accept     = (state_q == GEN) && !used[k];

  always_comb begin
    state_d = state_q;
    if (regen) state_d = GEN;
    else if (accept && cnt == 3'd6) state_d = RUN;
  end

  // Index 0 is preset as used, so Q[0] keeps its cleared value of 0
  always_ff @(posedge clk) begin
    if (rst || regen) begin
      used  <= 8'h01;
      cnt   <= 3'd0;
      q_tab <= '0;
    end else if (accept) begin
      used[k]  <= 1'b1;
      q_tab[k] <= cnt + 3'd1;
      cnt      <= cnt + 3'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= GEN;
    else     state_q <= state_d;
  end

  assign table_ready = (state_q == RUN);
  assign in_ready    = (state_q == RUN) && (!vld_p1 || out_ready);
  assign xfer        = in_valid && in_ready && !regen;

  // Stage p1: single output register; regen drops any held word
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (regen) begin
      vld_p1 <= 1'b0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= apply_q(Secventa_Intretesuta, q_tab);
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid              = vld_p1;
  assign Secventa_Deintretesuta = data_p1;

endmodule

// File: tb/tb_deinterleaver_gf11.sv
// Self-checking bench for deinterleaver_gf11: vector table, scoreboard, and
// hand-written sequences for generation timing, backpressure, regen and mid-GEN reset.
module tb_deinterleaver_gf11;

  logic       clk = 1'b0;
  logic       rst, regen, in_valid, in_ready, out_valid, out_ready, table_ready;
  logic [7:0] din, dout;

  int         tests = 0;
  int         fails = 0;
  int         n;
  logic [7:0] sb[$];
  bit         use_want;
  logic [7:0] want;
  logic [2:0] pf[8] = '{3'd0, 3'd7, 3'd2, 3'd6, 3'd3, 3'd4, 3'd1, 3'd5};

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  deinterleaver_gf11 dut (
    .clk                    (clk),
    .rst                    (rst),
    .regen                  (regen),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .Secventa_Intretesuta   (din),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .Secventa_Deintretesuta (dout),
    .table_ready            (table_ready)
  );

  function automatic logic [7:0] fwd(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[pf[i]];
    return r;
  endfunction

  // Undo the forward map: bit i of the interleaved word came from bit pf[i]
  function automatic logic [7:0] inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) r[pf[i]] = x[i];
    return r;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got 0x%02h, want no output", dout);
      end else begin
        chk8("sb_data", dout, sb.pop_front());
      end
    end
    if (regen) sb.delete();
    if (in_valid && in_ready && !regen) sb.push_back(use_want ? want : inv(din));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_table(output int cycles);
    cycles = 0;
    #1;
    while (!table_ready && cycles < 40) begin
      step();
      cycles++;
      #1;
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < 5; i++) begin
      din      = tbl[i].din;
      in_valid = 1'b1;
      #1;
      chk1("tput_in_ready", in_ready, 1'b1);
      if (i > 0) begin
        chk1("tbl_vld", out_valid, 1'b1);
        chk8("tbl_out", dout, tbl[i-1].exp);
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    chk8("tbl_out_last", dout, tbl[4].exp);
    step();
  endtask

  initial begin
    rst = 1'b1; regen = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din = 8'h00;
    use_want = 1'b0; want = 8'h00;
    tbl[0] = '{8'h01, 8'h01};
    tbl[1] = '{8'h80, 8'h20};
    tbl[2] = '{8'hFF, 8'hFF};
    tbl[3] = '{8'h00, 8'h00};
    tbl[4] = '{8'hA5, 8'h35};

    repeat (3) @(negedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_table_ready", table_ready, 1'b0);
    chk8("rst_data", dout, 8'h00);

    // Generation after reset, input already waiting
    rst = 1'b0; in_valid = 1'b1; din = 8'h02;
    wait_table(n);
    chk_int("gen_cycles", n, 14);
    chk1("gen_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    #1;
    chk1("first_vld", out_valid, 1'b1);
    chk8("first_out", dout, 8'h80);
    step();

    run_table();

    // Round trip through the forward map
    use_want = 1'b1;
    for (int x = 0; x < 256; x++) begin
      din = fwd(8'(x)); want = 8'(x); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    use_want = 1'b0;
    chk_int("rt_drained", sb.size(), 0);

    // Backpressure for 5 cycles
    din = 8'h5A; in_valid = 1'b1;
    step();
    out_ready = 1'b0; din = 8'hC3;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_vld", out_valid, 1'b1);
      chk8("bp_hold", dout, inv(8'h5A));
      step();
    end
    out_ready = 1'b1;
    step();
    din = 8'h3C;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk_int("bp_drained", sb.size(), 0);

    // regen while a word is held
    din = 8'h01; in_valid = 1'b1;
    step();
    din = 8'h80;
    step();
    out_ready = 1'b0; regen = 1'b1; din = 8'hFF;
    #1;
    chk1("pre_regen_vld", out_valid, 1'b1);
    step();
    regen = 1'b0; out_ready = 1'b1;
    #1;
    chk1("regen_vld_clr", out_valid, 1'b0);
    chk1("regen_tr_low", table_ready, 1'b0);
    wait_table(n);
    chk_int("regen_cycles", n, 14);
    run_table();

    // Reset landing in GEN cycle 8
    in_valid = 1'b0; regen = 1'b1;
    step();
    regen = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk1("rstmid_tr", table_ready, 1'b0);
    chk1("rstmid_in_ready", in_ready, 1'b0);
    wait_table(n);
    chk_int("rstmid_cycles", n, 14);
    for (int i = 0; i < 8; i++) begin
      din = 8'(1) << i; in_valid = 1'b1;
      #1;
      if (i > 0) chk8("onehot", dout, 8'(1) << pf[i-1]);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk8("onehot_last", dout, 8'(1) << pf[7]);
    step();
    chk_int("final_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
